alu_op_sequencer: RTL

Command-side front end for the 8-bit `alu` datapath. It accepts tagged operation requests over a valid/ready stream and buffers them in a small FIFO. It issues one operation at a time to the ALU's registered operand and select inputs, captures the registered result and carry, and returns an in-order tagged response over a second valid/ready stream. Operations the ALU cannot compute meaningfully (divide-by-zero, undefined select) are trapped locally and never reach the ALU.

---
 rtl/alu_op_sequencer_pkg.sv | 49 ++++
 rtl/alu_op_sequencer_if.sv | 52 +++++
 rtl/alu_op_sequencer_cmd_fifo.sv | 63 ++++++
 rtl/alu_op_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer shared definitions: ALU op codes, trap result
// constants, the queued command record and the sequencer state encoding.
// No ports; imported by the FIFO, the interface users and the top.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_DIV = 4'd3;

    localparam logic [7:0] ALU_ERR_RESULT  = 8'hAC;
    localparam logic [7:0] ALU_DIV0_RESULT = 8'hFF;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [3:0] tag;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } seq_state_e;

    // True when the select names an operation the ALU implements.
    function automatic logic sel_known(input logic [3:0] sel);
        logic known;
        known = 1'b0;
        case (sel)
            ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV: known = 1'b1;
            default: known = 1'b0;
        endcase
        return known;
    endfunction

    // Commands that must never reach the ALU.
    function automatic logic is_trap(input alu_cmd_t c);
        return !sel_known(c.sel) || (c.sel == ALU_DIV && c.b == 8'd0);
    endfunction

    // Result reported for a trapped command.
    function automatic logic [7:0] trap_result(input alu_cmd_t c);
        return sel_known(c.sel) ? ALU_DIV0_RESULT : ALU_ERR_RESULT;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the sequencer's command stream, response stream, ALU drive
// and status signals. slave = sequencer side, master = environment side.
interface alu_op_sequencer_if;

    // command stream
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_sel;
    logic [3:0] cmd_tag;

    // ALU drive and return
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;

    // response stream
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_err;
    logic [3:0] rsp_tag;

    // status
    logic        busy;
    logic [15:0] ops_done;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_carry,
        output rsp_valid, rsp_result, rsp_carry, rsp_err, rsp_tag,
        input  rsp_ready,
        output busy, ops_done
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_carry,
        input  rsp_valid, rsp_result, rsp_carry, rsp_err, rsp_tag,
        output rsp_ready,
        input  busy, ops_done
    );

endinterface

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of alu_cmd_t, DEPTH a power of two.
// Ports: clock, reset (sync, high), push/din, pop/dout, full, empty, count.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  alu_cmd_t                 din,
    input  logic                     pop,
    output alu_cmd_t                 dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    alu_cmd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues tagged ALU requests, issues one at a time to
// the registered ALU inputs, traps div-by-zero / unknown selects locally
// and returns in-order tagged responses.
// Ports: clock, reset (sync, high), bus (alu_op_sequencer_if.slave:
// cmd stream, ALU drive/return, rsp stream, busy, ops_done).
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    alu_op_sequencer_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    alu_cmd_t   cmd_in;
    alu_cmd_t   head;
    logic       full;
    logic       empty;
    logic [CW-1:0] count;
    logic       push;
    logic       pop;

    seq_state_e  state;
    logic [7:0]  alu_a_q;
    logic [7:0]  alu_b_q;
    logic [3:0]  alu_sel_q;
    logic [7:0]  rsp_result_q;
    logic        rsp_carry_q;
    logic        rsp_err_q;
    logic [3:0]  rsp_tag_q;
    logic [15:0] done_cnt;

    assign cmd_in = '{
        a:   bus.cmd_a,
        b:   bus.cmd_b,
        sel: bus.cmd_sel,
        tag: bus.cmd_tag
    };

    assign push = bus.cmd_valid && !full;
    // Popping only from IDLE keeps a single operation in flight.
    assign pop  = (state == S_IDLE) && !empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
            done_cnt     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!empty) begin
                        rsp_tag_q <= head.tag;
                        if (is_trap(head)) begin
                            // ALU drive regs keep their last values.
                            rsp_result_q <= trap_result(head);
                            rsp_carry_q  <= 1'b0;
                            rsp_err_q    <= 1'b1;
                            state        <= S_RESP;
                        end else begin
                            alu_a_q   <= head.a;
                            alu_b_q   <= head.b;
                            alu_sel_q <= head.sel;
                            state     <= S_ISSUE;
                        end
                    end
                end
                // ALU samples its inputs at the end of this cycle.
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    rsp_result_q <= bus.alu_out;
                    rsp_carry_q  <= bus.alu_carry;
                    rsp_err_q    <= 1'b0;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        done_cnt <= done_cnt + 16'd1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = !full;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.rsp_valid  = (state == S_RESP);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.busy       = (state != S_IDLE) || (count != '0);
    assign bus.ops_done   = done_cnt;

endmodule
